// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller serving LSB loads/stores and instruction fetch
`timescale 1ns/1ps
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        lsb2mem_en,
  input  logic        lsb2mem_store_load,
  input  logic [31:0] lsb2mem_addr,
  input  logic [2:0]  lsb2mem_type,
  input  logic [31:0] lsb2mem_val,
  input  logic [2:0]  lsb2mem_load_id,
  output logic        mem_busy,
  output logic        mem2lsb_load_en,
  output logic [2:0]  mem2lsb_load_id,
  output logic [31:0] mem2lsb_load_val,
  input  logic        if2mem_en,
  input  logic [31:0] if2mem_addr,
  output logic        mem2if_en,
  output logic [31:0] mem2if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q, val_q, data_q;
  logic [2:0]  type_q, id_q;
  logic [31:0] a_q;
  logic [7:0]  dout_q;
  logic        lsb_en_q, if_en_q;
  logic [2:0]  lsb_id_q;
  logic [31:0] lsb_val_q, if_inst_q;

  logic [2:0]  nbytes_d, cnt_inc_d;
  logic [31:0] next_a_d, word_d, ext_d;
  logic [7:0]  dout_d;
  logic        io_stall_d, wr_go_d, accept_lsb_d, accept_if_d;

  assign cnt_inc_d    = cnt_q + 3'd1;
  assign next_a_d     = addr_q + {29'd0, cnt_inc_d};
  assign io_stall_d   = (addr_q[17:16] == IO_HI) && io_buffer_full;
  assign wr_go_d      = (state_q == STORE) && rdy_in && !io_stall_d;
  // Under flush only a committed store may enter; speculative loads/fetches are dropped.
  assign accept_lsb_d = lsb2mem_en && (lsb2mem_store_load || !flush);
  assign accept_if_d  = if2mem_en && !flush;

  always_comb begin
    case (type_q[1:0])
      2'b00:   nbytes_d = 3'd1;
      2'b01:   nbytes_d = 3'd2;
      default: nbytes_d = 3'd4;
    endcase
  end

  // Current capture merged with bytes already collected; cnt_q = k+1 while byte k is on mem_din.
  always_comb begin
    word_d = data_q;
    case (cnt_q)
      3'd1:    word_d[7:0]   = mem_din;
      3'd2:    word_d[15:8]  = mem_din;
      3'd3:    word_d[23:16] = mem_din;
      3'd4:    word_d[31:24] = mem_din;
      default: word_d = data_q;
    endcase
  end

  always_comb begin
    case (type_q)
      3'b000:  ext_d = {{24{word_d[7]}}, word_d[7:0]};
      3'b001:  ext_d = {{16{word_d[15]}}, word_d[15:0]};
      3'b100:  ext_d = {24'd0, word_d[7:0]};
      3'b101:  ext_d = {16'd0, word_d[15:0]};
      default: ext_d = word_d;
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    dout_d = val_q[15:8];
      2'd1:    dout_d = val_q[23:16];
      default: dout_d = val_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 32'd0;
      val_q     <= 32'd0;
      data_q    <= 32'd0;
      type_q    <= 3'd0;
      id_q      <= 3'd0;
      a_q       <= 32'd0;
      dout_q    <= 8'd0;
      lsb_en_q  <= 1'b0;
      if_en_q   <= 1'b0;
      lsb_id_q  <= 3'd0;
      lsb_val_q <= 32'd0;
      if_inst_q <= 32'd0;
    end else begin
      lsb_en_q <= 1'b0;
      if_en_q  <= 1'b0;
      if (rdy_in) begin
        case (state_q)
          IDLE: begin
            if (accept_lsb_d) begin
              addr_q  <= lsb2mem_addr;
              type_q  <= lsb2mem_type;
              val_q   <= lsb2mem_val;
              id_q    <= lsb2mem_load_id;
              cnt_q   <= 3'd0;
              a_q     <= lsb2mem_addr;
              dout_q  <= lsb2mem_val[7:0];
              state_q <= lsb2mem_store_load ? STORE : LOAD;
            end else if (accept_if_d) begin
              addr_q  <= if2mem_addr;
              type_q  <= 3'b010;
              cnt_q   <= 3'd0;
              a_q     <= if2mem_addr;
              state_q <= FETCH;
            end
          end
          LOAD, FETCH: begin
            if (flush) begin
              state_q <= IDLE;
              cnt_q   <= 3'd0;
            end else begin
              if (cnt_q != 3'd0) data_q <= word_d;
              if (cnt_q == nbytes_d) begin
                state_q <= IDLE;
                cnt_q   <= 3'd0;
                if (state_q == LOAD) begin
                  lsb_en_q  <= 1'b1;
                  lsb_id_q  <= id_q;
                  lsb_val_q <= ext_d;
                end else begin
                  if_en_q   <= 1'b1;
                  if_inst_q <= word_d;
                end
              end else begin
                cnt_q <= cnt_inc_d;
                // Never present an address past the access, IO reads may have side effects.
                if (cnt_inc_d < nbytes_d) a_q <= next_a_d;
              end
            end
          end
          STORE: begin
            if (wr_go_d) begin
              if (cnt_inc_d == nbytes_d) begin
                state_q <= IDLE;
                cnt_q   <= 3'd0;
              end else begin
                cnt_q  <= cnt_inc_d;
                a_q    <= next_a_d;
                dout_q <= dout_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_busy         = (state_q != IDLE);
  assign mem_wr           = wr_go_d;
  assign mem_a            = a_q;
  assign mem_dout         = dout_q;
  assign mem2lsb_load_en  = lsb_en_q;
  assign mem2lsb_load_id  = lsb_id_q;
  assign mem2lsb_load_val = lsb_val_q;
  assign mem2if_en        = if_en_q;
  assign mem2if_inst      = if_inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a byte-array reference model
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0, rdy_in = 1'b0, flush = 1'b0;
  logic        lsb2mem_en = 1'b0, lsb2mem_store_load = 1'b0;
  logic [31:0] lsb2mem_addr = 32'd0, lsb2mem_val = 32'd0;
  logic [2:0]  lsb2mem_type = 3'd0, lsb2mem_load_id = 3'd0;
  logic        if2mem_en = 1'b0;
  logic [31:0] if2mem_addr = 32'd0;
  logic [7:0]  mem_din = 8'd0;
  logic        io_buffer_full = 1'b0;
  logic        mem_busy, mem2lsb_load_en, mem2if_en, mem_wr;
  logic [2:0]  mem2lsb_load_id;
  logic [31:0] mem2lsb_load_val, mem2if_inst, mem_a;
  logic [7:0]  mem_dout;

  int checks = 0;
  int errors = 0;
  int lsb_pulses = 0;
  int if_pulses = 0;

  logic [7:0]  env_ram   [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  logic [39:0] wlog [$];

  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .lsb2mem_en(lsb2mem_en), .lsb2mem_store_load(lsb2mem_store_load),
    .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type),
    .lsb2mem_val(lsb2mem_val), .lsb2mem_load_id(lsb2mem_load_id),
    .mem_busy(mem_busy), .mem2lsb_load_en(mem2lsb_load_en),
    .mem2lsb_load_id(mem2lsb_load_id), .mem2lsb_load_val(mem2lsb_load_val),
    .if2mem_en(if2mem_en), .if2mem_addr(if2mem_addr),
    .mem2if_en(mem2if_en), .mem2if_inst(mem2if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] def_byte(input logic [31:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_ram.exists(a) ? env_ram[a] : def_byte(a);
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : def_byte(a);
  endfunction

  function automatic int size_of(input logic [2:0] t);
    return (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
    int n = size_of(t);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < n; k++) w = w | (32'(model_rd(a + 32'(k))) << (8 * k));
    if (!t[2] && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8 * n));
    return w;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v);
    logic [31:0] s;
    for (int k = 0; k < size_of(t); k++) begin
      s = v >> (8 * k);
      model_mem[a + 32'(k)] = s[7:0];
    end
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    env_ram[a] = b;
    model_mem[a] = b;
  endtask

  // RAM environment: one-cycle read latency, byte writes when mem_wr is high.
  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      env_ram[mem_a] = mem_dout;
      wlog.push_back({mem_a, mem_dout});
    end
    mem_din <= env_rd(mem_a);
  end

  always @(negedge clk) begin
    if (mem2lsb_load_en === 1'b1) lsb_pulses++;
    if (mem2if_en === 1'b1) if_pulses++;
  end

  task automatic lsb_req(input logic st, input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] v, input logic [2:0] id);
    lsb2mem_en = 1'b1; lsb2mem_store_load = st; lsb2mem_addr = a;
    lsb2mem_type = t; lsb2mem_val = v; lsb2mem_load_id = id;
    @(posedge clk); #1;
    lsb2mem_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && mem_busy; i++) next_cycle();
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL %s_timeout busy=%b required 0", name, mem_busy); end
  endtask

  task automatic test_reset();
    rdy_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({mem_wr, mem_busy, mem2lsb_load_en, mem2if_en} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b required 0000", {mem_wr, mem_busy, mem2lsb_load_en, mem2if_en}); end
    checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h required 0", mem_a); end
    checks++; if ({mem_dout, mem2lsb_load_id} !== 11'd0) begin errors++; $display("FAIL reset_dout_id got %h required 0", {mem_dout, mem2lsb_load_id}); end
    checks++; if ({mem2lsb_load_val, mem2if_inst} !== 64'd0) begin errors++; $display("FAIL reset_vals got %h required 0", {mem2lsb_load_val, mem2if_inst}); end
    next_cycle(); rst_in = 1'b1; next_cycle();
  endtask

  task automatic test_lw();
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    lsb_req(1'b0, 32'h100, 3'b010, 32'd0, 3'd5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin checks++; if (mem_a !== 32'h100 + 32'(k - 1)) begin errors++; $display("FAIL lw_addr_%0d got %h required %h", k, mem_a, 32'h100 + 32'(k - 1)); end end
      if (k == 5) begin checks++; if (mem2lsb_load_en !== 1'b0) begin errors++; $display("FAIL lw_early_pulse got %b required 0", mem2lsb_load_en); end end
      if (k == 6) begin
        checks++; if (mem2lsb_load_en !== 1'b1) begin errors++; $display("FAIL lw_pulse got %b required 1", mem2lsb_load_en); end
        checks++; if (mem2lsb_load_id !== 3'd5) begin errors++; $display("FAIL lw_id got %0d required 5", mem2lsb_load_id); end
        checks++; if (mem2lsb_load_val !== 32'h44332211) begin errors++; $display("FAIL lw_val got %h required 44332211", mem2lsb_load_val); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL lw_busy_end got %b required 0", mem_busy); end
      end
    end
    next_cycle();
  endtask

  task automatic test_lb_lbu();
    preload(32'h200, 8'h80);
    lsb_req(1'b0, 32'h200, 3'b000, 32'd0, 3'd3);
    repeat (3) @(negedge clk);
    checks++; if ({mem2lsb_load_en, mem2lsb_load_val} !== {1'b1, 32'hFFFFFF80}) begin errors++; $display("FAIL lb_val got %b/%h required 1/ffffff80", mem2lsb_load_en, mem2lsb_load_val); end
    next_cycle();
    lsb_req(1'b0, 32'h200, 3'b100, 32'd0, 3'd3);
    repeat (3) @(negedge clk);
    checks++; if ({mem2lsb_load_en, mem2lsb_load_val} !== {1'b1, 32'h00000080}) begin errors++; $display("FAIL lbu_val got %b/%h required 1/00000080", mem2lsb_load_en, mem2lsb_load_val); end
    next_cycle();
  endtask

  task automatic test_sh();
    lsb_req(1'b1, 32'h300, 3'b001, 32'hABCD1234, 3'd0);
    model_store(32'h300, 3'b001, 32'hABCD1234);
    @(negedge clk);
    checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'h34}) begin errors++; $display("FAIL sh_byte0 got %b/%h/%h required 1/300/34", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h301, 8'h12}) begin errors++; $display("FAIL sh_byte1 got %b/%h/%h required 1/301/12", mem_wr, mem_a, mem_dout); end
    @(negedge clk);
    checks++; if ({mem_wr, mem_busy} !== 2'b00) begin errors++; $display("FAIL sh_end got wr=%b busy=%b required 0/0", mem_wr, mem_busy); end
    next_cycle();
  endtask

  task automatic test_priority();
    logic [31:0] exp_ld, exp_inst;
    int lp;
    exp_ld = model_load(32'h180, 3'b010);
    exp_inst = model_load(32'h500, 3'b010);
    lp = if_pulses;
    if2mem_en = 1'b1; if2mem_addr = 32'h500;
    lsb_req(1'b0, 32'h180, 3'b010, 32'd0, 3'd2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin checks++; if (mem_a !== 32'h180) begin errors++; $display("FAIL prio_first got %h required 180", mem_a); end end
    end
    checks++; if ({mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val} !== {1'b1, 3'd2, exp_ld}) begin errors++; $display("FAIL prio_load got %b/%0d/%h required 1/2/%h", mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val, exp_ld); end
    next_cycle();
    if2mem_en = 1'b0;
    checks++; if (if_pulses != lp) begin errors++; $display("FAIL prio_no_if_pulse got %0d required %0d", if_pulses, lp); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin checks++; if (mem_a !== 32'h500) begin errors++; $display("FAIL prio_fetch_addr got %h required 500", mem_a); end end
    end
    checks++; if ({mem2if_en, mem2if_inst} !== {1'b1, exp_inst}) begin errors++; $display("FAIL prio_fetch got %b/%h required 1/%h", mem2if_en, mem2if_inst, exp_inst); end
    next_cycle();
  endtask

  task automatic test_flush();
    int lp;
    logic [31:0] v;
    lp = if_pulses;
    if2mem_en = 1'b1; if2mem_addr = 32'h600;
    next_cycle(); if2mem_en = 1'b0;
    next_cycle(); flush = 1'b1;
    next_cycle(); flush = 1'b0;
    @(negedge clk);
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL flush_fetch_idle got %b required 0", mem_busy); end
    repeat (8) next_cycle();
    checks++; if (if_pulses != lp) begin errors++; $display("FAIL flush_fetch_pulse got %0d required %0d", if_pulses, lp); end
    v = $urandom;
    wlog.delete();
    lsb_req(1'b1, 32'h700, 3'b010, v, 3'd0);
    model_store(32'h700, 3'b010, v);
    flush = 1'b1;
    repeat (3) next_cycle();
    flush = 1'b0;
    wait_idle("flush_sw");
    checks++;
    if (wlog.size() != 4) begin errors++; $display("FAIL flush_sw_count got %0d required 4", wlog.size()); end
    else for (int k = 0; k < 4; k++)
      if (wlog[k] !== {32'h700 + 32'(k), model_rd(32'h700 + 32'(k))}) begin errors++; $display("FAIL flush_sw_w%0d got %h required %h", k, wlog[k], {32'h700 + 32'(k), model_rd(32'h700 + 32'(k))}); end
  endtask

  task automatic test_flush_idle();
    int lp;
    lp = lsb_pulses;
    flush = 1'b1; if2mem_en = 1'b1; if2mem_addr = 32'h640;
    lsb_req(1'b0, 32'h100, 3'b010, 32'd0, 3'd1);
    flush = 1'b0; if2mem_en = 1'b0;
    @(negedge clk);
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL flush_idle_drop got busy=%b required 0", mem_busy); end
    next_cycle();
    flush = 1'b1;
    lsb_req(1'b1, 32'h740, 3'b000, 32'h0000_00A5, 3'd0);
    flush = 1'b0;
    model_store(32'h740, 3'b000, 32'h0000_00A5);
    @(negedge clk);
    checks++; if ({mem_busy, mem_wr, mem_a, mem_dout} !== {2'b11, 32'h740, 8'hA5}) begin errors++; $display("FAIL flush_idle_store got %b%b/%h/%h required 11/740/a5", mem_busy, mem_wr, mem_a, mem_dout); end
    next_cycle();
    wait_idle("flush_idle_store");
    checks++; if (lsb_pulses != lp) begin errors++; $display("FAIL flush_idle_pulse got %0d required %0d", lsb_pulses, lp); end
  endtask

  task automatic test_io();
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h0002_0010, 3'b000, 32'h0000_0033, 3'd0);
    model_store(32'h0002_0010, 3'b000, 32'h0000_0033);
    @(negedge clk);
    checks++; if ({mem_wr, mem_a} !== {1'b1, 32'h0002_0010}) begin errors++; $display("FAIL io_nonio_write got %b/%h required 1/00020010", mem_wr, mem_a); end
    next_cycle();
    wlog.delete();
    lsb_req(1'b1, 32'h0003_0000, 3'b000, 32'h1234_565C, 3'd0);
    model_store(32'h0003_0000, 3'b000, 32'h1234_565C);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_stall_%0d got wr=%b required 0", k, mem_wr); end
    end
    next_cycle();
    io_buffer_full = 1'b0;
    @(negedge clk);
    checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h0003_0000, 8'h5C}) begin errors++; $display("FAIL io_write got %b/%h/%h required 1/00030000/5c", mem_wr, mem_a, mem_dout); end
    next_cycle();
    @(negedge clk);
    checks++; if ({mem_wr, mem_busy} !== 2'b00 || wlog.size() != 1) begin errors++; $display("FAIL io_single got wr=%b busy=%b writes=%0d required 0/0/1", mem_wr, mem_busy, wlog.size()); end
    next_cycle();
  endtask

  task automatic test_rdy();
    logic [31:0] v;
    rdy_in = 1'b0;
    lsb2mem_en = 1'b1; lsb2mem_store_load = 1'b0; lsb2mem_addr = 32'h100; lsb2mem_type = 3'b010;
    repeat (2) next_cycle();
    lsb2mem_en = 1'b0;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rdy_low_accept got busy=%b required 0", mem_busy); end
    rdy_in = 1'b1;
    v = $urandom;
    wlog.delete();
    lsb_req(1'b1, 32'h800, 3'b010, v, 3'd0);
    model_store(32'h800, 3'b010, v);
    next_cycle();
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({mem_wr, mem_busy, mem_a} !== {2'b01, 32'h801}) begin errors++; $display("FAIL rdy_hold_%0d got wr=%b busy=%b a=%h required 0/1/801", k, mem_wr, mem_busy, mem_a); end
      next_cycle();
    end
    rdy_in = 1'b1;
    wait_idle("rdy_store");
    checks++;
    if (wlog.size() != 4) begin errors++; $display("FAIL rdy_store_count got %0d required 4", wlog.size()); end
    else for (int k = 0; k < 4; k++)
      if (wlog[k] !== {32'h800 + 32'(k), model_rd(32'h800 + 32'(k))}) begin errors++; $display("FAIL rdy_store_w%0d got %h", k, wlog[k]); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_ld;
    exp_ld = model_load(32'hFFFF_FFFE, 3'b010);
    lsb_req(1'b0, 32'hFFFF_FFFE, 3'b010, 32'd0, 3'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) begin checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL wrap_addr got %h required 0", mem_a); end end
    end
    checks++; if ({mem2lsb_load_en, mem2lsb_load_val} !== {1'b1, exp_ld}) begin errors++; $display("FAIL wrap_val got %b/%h required 1/%h", mem2lsb_load_en, mem2lsb_load_val, exp_ld); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int lp;
    lp = lsb_pulses;
    lsb_req(1'b0, 32'h100, 3'b010, 32'd0, 3'd4);
    next_cycle();
    rst_in = 1'b0; #1;
    checks++; if ({mem_busy, mem_a} !== 33'd0) begin errors++; $display("FAIL rstmid_async got busy=%b a=%h required 0/0", mem_busy, mem_a); end
    next_cycle(); rst_in = 1'b1;
    repeat (8) next_cycle();
    checks++; if (lsb_pulses != lp) begin errors++; $display("FAIL rstmid_pulse got %0d required %0d", lsb_pulses, lp); end
    wlog.delete();
    lsb_req(1'b1, 32'h900, 3'b010, 32'hCAFEF00D, 3'd0);
    next_cycle();
    rst_in = 1'b0;
    next_cycle(); rst_in = 1'b1;
    repeat (6) next_cycle();
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL rstmid_writes got %0d required 1", wlog.size()); end
  endtask

  task automatic test_random();
    logic [2:0]  ltypes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] a, v, exp;
    logic [2:0]  t, id;
    int op, n, lat, lp;
    bit got;
    for (int it = 0; it < 48; it++) begin
      op = $urandom_range(0, 2);
      a = 32'h1000 + 32'($urandom_range(0, 63));
      if (op == 0) begin
        t = 3'($urandom_range(0, 2));
        v = $urandom;
        n = size_of(t);
        wlog.delete();
        lsb_req(1'b1, a, t, v, 3'd0);
        model_store(a, t, v);
        for (int i = 0; i < 40 && mem_busy; i++) begin
          rdy_in = ($urandom_range(0, 3) != 0);
          next_cycle();
        end
        rdy_in = 1'b1;
        wait_idle("rand_store");
        checks++;
        if (wlog.size() != n) begin errors++; $display("FAIL rand_store_count got %0d required %0d", wlog.size(), n); end
        else for (int k = 0; k < n; k++)
          if (wlog[k] !== {a + 32'(k), model_rd(a + 32'(k))}) begin errors++; $display("FAIL rand_store_w%0d got %h required %h", k, wlog[k], {a + 32'(k), model_rd(a + 32'(k))}); end
      end else begin
        t = (op == 1) ? ltypes[$urandom_range(0, 4)] : 3'b010;
        id = 3'($urandom_range(0, 7));
        exp = model_load(a, t);
        n = size_of(t);
        lp = (op == 1) ? if_pulses : lsb_pulses;
        if (op == 1) lsb_req(1'b0, a, t, 32'd0, id);
        else begin if2mem_en = 1'b1; if2mem_addr = a; next_cycle(); if2mem_en = 1'b0; end
        got = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
          @(negedge clk);
          if ((op == 1 && mem2lsb_load_en) || (op == 2 && mem2if_en)) begin got = 1'b1; break; end
        end
        checks++; if (!got || lat != n + 2) begin errors++; $display("FAIL rand_latency got %0d required %0d (op %0d)", lat, n + 2, op); end
        checks++;
        if (op == 1 && {mem2lsb_load_id, mem2lsb_load_val} !== {id, exp}) begin errors++; $display("FAIL rand_load got %0d/%h required %0d/%h (type %b addr %h)", mem2lsb_load_id, mem2lsb_load_val, id, exp, t, a); end
        if (op == 2 && mem2if_inst !== exp) begin errors++; $display("FAIL rand_fetch got %h required %h (addr %h)", mem2if_inst, exp, a); end
        next_cycle();
        checks++; if (((op == 1) ? if_pulses : lsb_pulses) != lp) begin errors++; $display("FAIL rand_wrong_port got a pulse on the other port (op %0d)", op); end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_priority();
    test_flush();
    test_flush_idle();
    test_io();
    test_rdy();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
